// File: rtl/mul_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Operand/product widths, FIFO entry layout, round-robin step.
package mul_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;
    localparam int MAX_ID_W  = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0]  id;
        logic [PRODUCT_W-1:0] product;
    } mul_entry_t;

    function automatic int rr_next(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester, multiplier and response signals of the arbiter.
// slave is the arbiter's view, master the environment's view.
interface mul_share_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
);
    import mul_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*OPERAND_W-1:0] req_a;
    logic [NUM_REQ*OPERAND_W-1:0] req_b;
    logic [OPERAND_W-1:0]         mul_a;
    logic [OPERAND_W-1:0]         mul_b;
    logic [PRODUCT_W-1:0]         mul_product;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [PRODUCT_W-1:0]         rsp_product;
    logic [CNT_W-1:0]             inflight;

    modport master (
        output req_valid, req_a, req_b, mul_product, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id,
        input  rsp_product, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_product, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id,
        output rsp_product, inflight
    );

endinterface

// File: rtl/mul_rsp_fifo.sv
// Synchronous result FIFO, power-of-2 depth, wrapping pointers.
// Head entry is presented combinationally on o_rdata.
module mul_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one registered multiplier between requesters.
// Credit on inflight guarantees the result FIFO never overflows.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_share_arb_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(mul_entry_t);

    logic [ID_W-1:0]    r_ptr;
    logic [CW-1:0]      r_inflight;
    logic [MUL_LAT-1:0] r_tag_v;
    logic [ID_W-1:0]    r_tag_id [MUL_LAT];

    logic               w_hit;
    logic [ID_W-1:0]    w_gid;
    int                 w_idx;
    logic               w_credit;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    mul_entry_t         w_wentry;
    mul_entry_t         w_rentry;
    logic [EW-1:0]      w_rdata;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CW-1:0]      w_fifo_count;

    assign w_credit = (r_inflight < CW'(FIFO_DEPTH));
    assign w_grant  = rst_n & w_hit & w_credit;
    assign w_pop    = ~w_fifo_empty & bus.rsp_ready;
    assign w_push   = r_tag_v[MUL_LAT-1];

    // First valid requester at or after the RR pointer, with wrap.
    always_comb begin
        w_hit = 1'b0;
        w_gid = '0;
        w_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_hit && bus.req_valid[w_idx]) begin
                w_hit = 1'b1;
                w_gid = ID_W'(w_idx);
            end
        end
    end

    // Grant and operand drive; operands are zero when idle.
    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        if (w_grant) begin
            bus.req_ready[w_gid] = 1'b1;
            bus.mul_a = bus.req_a[int'(w_gid)*OPERAND_W +: OPERAND_W];
            bus.mul_b = bus.req_b[int'(w_gid)*OPERAND_W +: OPERAND_W];
        end
    end

    // Tag pipeline follows each operand pair through the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int s = 0; s < MUL_LAT; s++) r_tag_id[s] <= '0;
        end else begin
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_gid;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // RR pointer advance and issued-but-not-popped accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_inflight <= '0;
        end else begin
            if (w_grant) r_ptr <= ID_W'(rr_next(int'(w_gid), NUM_REQ));
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_pop);
        end
    end

    // Pack the returning tag id with the product.
    always_comb begin
        w_wentry = '0;
        w_wentry.id[ID_W-1:0] = r_tag_id[MUL_LAT-1];
        w_wentry.product      = bus.mul_product;
    end

    mul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_rentry        = mul_entry_t'(w_rdata);
    assign bus.rsp_valid   = ~w_fifo_empty;
    assign bus.rsp_id      = w_rentry.id[ID_W-1:0];
    assign bus.rsp_product = w_rentry.product;
    assign bus.inflight    = r_inflight;

    // Credit must keep the FIFO within bounds and ids in range.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && w_fifo_full && !w_pop));
            assert (w_fifo_count <= r_inflight);
            if (!w_fifo_empty) assert (int'(w_rentry.id) < NUM_REQ);
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Random and directed stimulus for mul_share_arb with a
// queue-based reference model and scoreboard.
module tb_mul_share_arb;
    import mul_pkg::*;

    localparam int NR = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_arb_if #(.NUM_REQ(NR), .ID_W(2), .FIFO_DEPTH(FD)) bus ();

    mul_share_arb #(
        .NUM_REQ    (NR),
        .MUL_LAT    (1),
        .FIFO_DEPTH (FD),
        .ID_W       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered multiplier owned by the environment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mul_product <= '0;
        else bus.mul_product <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [63:0] p;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          m_ptr = 0;
    int          cyc = 0;
    int          eg;
    logic [3:0]  er;
    bit          ev;
    logic [31:0] ta;
    logic [31:0] tb_op;

    // Reference model + scoreboard, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m_ptr = 0;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_inflight", bus.inflight, 0);
            chk("rst_mul_a", bus.mul_a, 0);
            chk("rst_mul_b", bus.mul_b, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_product", bus.rsp_product, 0);
        end else begin
            chk("inflight", bus.inflight, sb.size());
            eg = -1;
            if (sb.size() < FD) begin
                for (int k = 0; k < NR; k++) begin
                    if (eg < 0 && bus.req_valid[(m_ptr + k) % NR])
                        eg = (m_ptr + k) % NR;
                end
            end
            er = (eg >= 0) ? 4'(1 << eg) : 4'b0;
            chk("req_ready", bus.req_ready, er);
            ev = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
            chk("rsp_valid", bus.rsp_valid, ev);
            if (ev) begin
                chk("rsp_id", bus.rsp_id, sb[0].id);
                chk("rsp_product", bus.rsp_product, sb[0].p);
            end
            if (eg >= 0) begin
                ta    = bus.req_a[eg*32 +: 32];
                tb_op = bus.req_b[eg*32 +: 32];
                chk("mul_a", bus.mul_a, ta);
                chk("mul_b", bus.mul_b, tb_op);
                sb.push_back('{eg, {32'b0, ta} * {32'b0, tb_op}, cyc});
                m_ptr = (eg + 1) % NR;
            end else begin
                chk("mul_a_idle", bus.mul_a, 0);
                chk("mul_b_idle", bus.mul_b, 0);
            end
            if (ev && bus.rsp_ready) void'(sb.pop_front());
        end
    end

    logic [3:0] xf = '0;

    // Requesters hold operands until their transfer completes.
    task automatic run(int n, logic [3:0] mask, int pv, int pr, bit maxop);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i] || xf[i]) begin
                    bus.req_valid[i] = mask[i] && ($urandom_range(99) < pv);
                    bus.req_a[i*32 +: 32] = maxop ? 32'hFFFF_FFFF : $urandom();
                    bus.req_b[i*32 +: 32] = maxop ? 32'hFFFF_FFFF : $urandom();
                end
            end
            bus.rsp_ready = ($urandom_range(99) < pr);
            @(negedge clk);
            xf = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        xf = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        do_reset();

        bus.req_valid = 4'b0001;
        bus.req_a[31:0] = 32'd3;
        bus.req_b[31:0] = 32'd5;
        run(6, 4'b0000, 0, 100, 1'b0);

        run(40, 4'hF, 100, 100, 1'b0);
        run(8, 4'b0000, 0, 100, 1'b0);

        run(1, 4'b0010, 100, 100, 1'b1);
        run(6, 4'b0000, 0, 100, 1'b0);

        run(10, 4'b0010, 100, 0, 1'b0);
        @(negedge clk);
        chk("bp_inflight", bus.inflight, 4);
        chk("bp_ready", bus.req_ready, 0);
        xf = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        run(1, 4'b0010, 100, 100, 1'b0);
        run(3, 4'b0010, 100, 0, 1'b0);
        run(10, 4'b0000, 0, 100, 1'b0);

        run(3, 4'b0010, 100, 0, 1'b0);
        run(1, 4'b0010, 100, 100, 1'b0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("pg_inflight", bus.inflight, 3);
        xf = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        run(10, 4'b0000, 0, 100, 1'b0);

        run(400, 4'hF, 60, 50, 1'b0);
        run(150, 4'hF, 90, 25, 1'b0);
        run(12, 4'b0000, 0, 100, 1'b0);

        run(1, 4'hF, 100, 100, 1'b0);
        do_reset();
        bus.req_valid = 4'b1100;
        bus.req_a[95:64] = $urandom();
        bus.req_b[95:64] = $urandom();
        bus.req_a[127:96] = $urandom();
        bus.req_b[127:96] = $urandom();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_pick2", bus.req_ready, 4'b0100);
        xf = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        run(12, 4'b0000, 0, 100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
